hidden_cpu_sequencer: RTL
=========================

Name: hidden_cpu_sequencer

Overview:
Instruction sequencer for the 8-bit hidden CPU core. It holds a small program store of 6-bit instructions (opcode[1:0] and register addresses[3:0]) and loads it through a valid/ready byte stream. It then drives the core's instruction field and reset, one instruction per issue cycle, with branch redirect, single-step, halt and watchdog control. It sits between the chip pins or test harness and the core's instruction inputs.

Parameters:
DEPTH, 16, program store entries (power of two)
ADDR_W, 4, log2(DEPTH)
MAX_CYCLES, 1000, watchdog limit on issued instructions per run

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
load_start  in  1  pulse: begin program load (honoured in IDLE/DONE only)
ld_valid  in  1  load data valid
ld_data  in  6  instruction {opcode[1:0], addrs[3:0]}
ld_last  in  1  marks final load word, qualified by ld_valid
ld_ready  out  1  store accepts a word
run_start  in  1  pulse: run the loaded program (honoured in IDLE/DONE only)
step_mode  in  1  1 = issue only on step_req pulses
step_req  in  1  single-step request
halt_req  in  1  stop run, go to DONE
br_taken  in  1  core reports a taken branch for the instruction issued last cycle
br_off  in  8  branch offset (core r3), two's-complement not applied, unsigned add
instr_valid  out  1  instr is live this cycle
instr  out  6  instruction to core io_in[7:2]
core_rst  out  1  reset to core
busy  out  1  state is LOAD, PRIME or RUN
done  out  1  level: state is DONE
timeout  out  1  sticky: last run ended by watchdog
prog_len  out  ADDR_W+1  words loaded
issue_cnt  out  16  instructions issued this run, saturating at 16'hFFFF

Behaviour:
- Reset, asynchronous: state=IDLE; ptr=0; prog_len=0; issue_cnt=0; instr=0; instr_valid=0; ld_ready=0; core_rst=1; busy=0; done=0; timeout=0. Store contents are not reset. Reset mid-load or mid-run aborts immediately.
- IDLE: core_rst=1. load_start -> LOAD with wr_ptr=0. run_start -> PRIME, or -> DONE if prog_len==0. If both are pulsed in the same cycle, load_start wins.
- LOAD: ld_ready = (wr_ptr<DEPTH). A handshake (ld_valid&ld_ready) writes store[wr_ptr] and increments wr_ptr. The handshake with ld_last, or the write that makes wr_ptr==DEPTH, commits prog_len=wr_ptr+1 and goes to IDLE next cycle. Words offered while ld_ready=0 are dropped. Load never leaves LOAD without a terminating handshake.
- PRIME: exactly one cycle. core_rst=1, instr_valid=0. Clears ptr, issue_cnt and timeout. Then -> RUN.
- RUN: core_rst=0. instr=store[ptr]; output is registered, so instr reflects the ptr of the previous cycle.
  - Issue fires every cycle if step_mode=0, or only in cycles with step_req=1 if step_mode=1. instr_valid=1 only in cycles that issue. In non-issue cycles instr holds its value and ptr holds.
  - On issue: issue_cnt++ (saturating). ptr_next = br_taken ? (ptr+br_off) mod 2^ADDR_W : ptr+1. br_taken is sampled only in an issue cycle and refers to the previous issued instruction.
  - End conditions, priority order:
    1. halt_req -> DONE.
    2. Issue count reaches MAX_CYCLES -> DONE, timeout=1.
    3. ptr_next >= prog_len, with no wrap -> DONE after the final instruction issues.
  - halt_req beats br_taken and step_req in the same cycle.
- DONE: done=1, core_rst=0 so core outputs stay observable, instr_valid=0. load_start -> LOAD; run_start -> PRIME; halt_req is ignored.
- ptr arithmetic is ADDR_W bits and wraps modulo DEPTH; wrap alone never ends a run, the prog_len check does. prog_len=DEPTH is legal.
- Latency: run_start in cycle N; core_rst high in cycle N+1 (PRIME); first instr_valid in cycle N+2 carrying store[0].

Decomposition:
- Package hidden_cpu_pkg:
  - state encoding localparams S_IDLE, S_LOAD, S_PRIME, S_RUN, S_DONE (3-bit)
  - opcode constants for the 2-bit opcode field
  - instruction width constant INSTR_W=6
- One sub-module, hidden_prog_store: DEPTH x INSTR_W register file, 1 synchronous write port, 1 asynchronous read port, no reset.

Test Plan:
- Load 5 words 6'h01..6'h05 with ld_last on the 5th -> prog_len=5, ld_ready drops, IDLE one cycle after the last handshake.
- run_start with step_mode=0 -> core_rst=1 for 1 cycle, then instr=01,02,03,04,05 on 5 consecutive valid cycles; DONE, issue_cnt=5, timeout=0.
- Load 16 words without ld_last -> auto-commit prog_len=16; 17th offered word has ld_ready=0 and is dropped; run wraps to 0 only via a branch.
- br_taken=1 with br_off=8'hFF on the 2nd issue of a 4-word program -> ptr wraps to entry 0 (loop). With MAX_CYCLES=10 -> exactly 10 issues, then DONE with timeout=1.
- step_mode=1, step_req pulsed 3 times with gaps -> exactly 3 instr_valid pulses, instr stable between them; halt_req together with step_req -> no issue, DONE.
- Assert rst mid-RUN -> all outputs at reset values in the same cycle (asynchronous); run_start with prog_len=0 after reset -> DONE directly, no PRIME.

Source files
------------

// File: rtl/hidden_cpu_pkg.sv
// Shared constants for the hidden CPU instruction sequencer: FSM encodings,
// opcode field values and instruction width.
package hidden_cpu_pkg;

    localparam int unsigned INSTR_W = 6;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_PRIME = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Opcode field, instr[5:4]
    localparam logic [1:0] OP_MOV = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_BR  = 2'b11;

endpackage

// File: rtl/hidden_prog_store.sv
// Program store: DEPTH x INSTR_W register file, one synchronous write port,
// one asynchronous read port, contents not reset.
module hidden_prog_store
    import hidden_cpu_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  wrAddr,
    input  logic [INSTR_W-1:0] wrData,
    input  logic [ADDR_W-1:0]  rdAddr,
    output logic [INSTR_W-1:0] rdData
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/hidden_cpu_sequencer.sv
// Instruction sequencer for the 8-bit hidden CPU: loads a program over a
// valid/ready stream, then issues it with branch, step, halt and watchdog.
module hidden_cpu_sequencer
    import hidden_cpu_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned MAX_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_start,
    input  logic               ld_valid,
    input  logic [INSTR_W-1:0] ld_data,
    input  logic               ld_last,
    output logic               ld_ready,
    input  logic               run_start,
    input  logic               step_mode,
    input  logic               step_req,
    input  logic               halt_req,
    input  logic               br_taken,
    input  logic [7:0]         br_off,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic               core_rst,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [ADDR_W:0]    prog_len,
    output logic [15:0]        issue_cnt
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

    logic [2:0]         state;
    logic [ADDR_W-1:0]  ptr;
    logic [ADDR_W:0]    wrPtr;
    logic               ldFire;
    logic               ldEnd;
    logic               issue;
    logic [ADDR_W-1:0]  brTarget;
    logic [ADDR_W:0]    ptrNextWide;
    logic               endProg;
    logic [15:0]        cntNext;
    logic               hitMax;
    logic [ADDR_W-1:0]  rdAddr;
    logic [INSTR_W-1:0] rdData;
    logic               unusedBrHi;

    assign ld_ready = (state == S_LOAD) && (wrPtr < DEPTH_W);
    assign ldFire   = ld_valid && ld_ready;
    assign ldEnd    = ldFire && (ld_last || (wrPtr == DEPTH_W - ONE_W));

    assign issue = (state == S_RUN) && !halt_req && (!step_mode || step_req);

    // Branch target wraps modulo DEPTH; sequential advance keeps the carry so
    // running off the end of a full store is caught by the prog_len compare.
    assign brTarget    = ptr + br_off[ADDR_W-1:0];
    assign unusedBrHi  = ^br_off[7:ADDR_W];
    assign ptrNextWide = br_taken ? {1'b0, brTarget} : ({1'b0, ptr} + ONE_W);
    assign endProg     = ptrNextWide >= prog_len;

    assign cntNext = (issue_cnt == 16'hFFFF) ? issue_cnt : issue_cnt + 16'd1;
    assign hitMax  = 32'(cntNext) >= MAX_CYCLES;

    // instr is registered from the address the next cycle will issue.
    assign rdAddr = (state == S_RUN) ? ptrNextWide[ADDR_W-1:0] : '0;

    assign instr_valid = issue;
    assign core_rst    = !((state == S_RUN) || (state == S_DONE));
    assign busy        = (state == S_LOAD) || (state == S_PRIME) || (state == S_RUN);
    assign done        = (state == S_DONE);

    hidden_prog_store #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_store (
        .clk    (clk),
        .we     (ldFire),
        .wrAddr (wrPtr[ADDR_W-1:0]),
        .wrData (ld_data),
        .rdAddr (rdAddr),
        .rdData (rdData)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            wrPtr     <= '0;
            prog_len  <= '0;
            issue_cnt <= '0;
            instr     <= '0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (load_start) begin
                        state <= S_LOAD;
                        wrPtr <= '0;
                    end else if (run_start) begin
                        state <= (prog_len == '0) ? S_DONE : S_PRIME;
                    end
                end
                S_LOAD: begin
                    if (ldFire) begin
                        wrPtr <= wrPtr + ONE_W;
                    end
                    if (ldEnd) begin
                        prog_len <= wrPtr + ONE_W;
                        state    <= S_IDLE;
                    end
                end
                S_PRIME: begin
                    ptr       <= '0;
                    issue_cnt <= '0;
                    timeout   <= 1'b0;
                    instr     <= rdData;
                    state     <= S_RUN;
                end
                S_RUN: begin
                    if (halt_req) begin
                        state <= S_DONE;
                    end else if (issue) begin
                        issue_cnt <= cntNext;
                        ptr       <= ptrNextWide[ADDR_W-1:0];
                        instr     <= rdData;
                        if (hitMax) begin
                            state   <= S_DONE;
                            timeout <= 1'b1;
                        end else if (endProg) begin
                            state <= S_DONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
